// File: rtl/rpsc_pkg.sv
// rpsc_pkg: shared types and helpers for the RPSC interlock front-end and
// fault-latch cards.
package rpsc_pkg;

    // Per-channel debounce qualification states.
    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        QUAL_HI   = 2'd1,
        STABLE_HI = 2'd2,
        QUAL_LO   = 2'd3
    } deb_state_e;

    // Width of each per-channel glitch counter.
    localparam int unsigned GLITCH_W = 8;

    // Widest channel vector the priority helper accepts.
    localparam int unsigned MAX_CH = 64;

    // Index of the lowest set bit of vec; 0 when vec is all zeros.
    function automatic int unsigned lowest_set_idx(input logic [MAX_CH-1:0] vec);
        int unsigned idx;
        logic        found;
        idx   = 0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_CH; i++) begin
            if (vec[i] && !found) begin
                idx   = i;
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rpsc_debounce_ch.sv
// rpsc_debounce_ch: one interlock channel -- two-flop synchroniser,
// qualification FSM with counter, registered rising-edge pulse.
// Optional glitch counter compiled only with RPSC_GLITCH_CNT_EN.
module rpsc_debounce_ch
    import rpsc_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 16,
    parameter int unsigned CNT_W      = $clog2(DEB_CYCLES)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                raw_i,
`ifdef RPSC_GLITCH_CNT_EN
    input  logic                ack_i,
    output logic [GLITCH_W-1:0] glitch_cnt_o,
`endif
    output logic                clean_o,
    output logic                clean_next_o,
    output logic                rise_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             s1_q;
    logic             s2_q;
    deb_state_e       state_q;
    deb_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             clean_q;
    logic             clean_d;
    logic             rise_q;

    // Synchroniser, FSM state, counter and clean/rise registers; fail-safe reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            state_q <= STABLE_HI;
            cnt_q   <= '0;
            clean_q <= 1'b1;
            rise_q  <= 1'b0;
        end else begin
            s1_q    <= raw_i;
            s2_q    <= s1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            rise_q  <= clean_d & ~clean_q;
        end
    end

    // Qualification: a new level must persist DEB_CYCLES synchronised cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clean_d = clean_q;
        case (state_q)
            STABLE_LO: begin
                if (s2_q) begin
                    state_d = QUAL_HI;
                    cnt_d   = CNT_W'(1);
                end
            end
            QUAL_HI: begin
                if (!s2_q) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                    clean_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STABLE_HI: begin
                if (!s2_q) begin
                    state_d = QUAL_LO;
                    cnt_d   = CNT_W'(1);
                end
            end
            QUAL_LO: begin
                if (s2_q) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                    clean_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = STABLE_HI;
                cnt_d   = '0;
                clean_d = 1'b1;
            end
        endcase
    end

    assign clean_o      = clean_q;
    assign clean_next_o = clean_d;
    assign rise_o       = rise_q;

`ifdef RPSC_GLITCH_CNT_EN
    logic                glitch_ev;
    logic [GLITCH_W-1:0] glitch_q;

    assign glitch_ev = ((state_q == QUAL_HI) && !s2_q) ||
                       ((state_q == QUAL_LO) &&  s2_q);

    // Saturating count of aborted qualifications; operator ack clears it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            glitch_q <= '0;
        end else if (ack_i) begin
            glitch_q <= '0;
        end else if (glitch_ev && (glitch_q != '1)) begin
            glitch_q <= glitch_q + 1'b1;
        end
    end

    assign glitch_cnt_o = glitch_q;
`endif

endmodule

// File: rtl/rpsc_interlock_conditioner.sv
// rpsc_interlock_conditioner: per-channel sync/debounce of raw interlock
// contacts feeding the fault-latch cards, plus OR-reduced fault flag and
// first-fault capture for the operator display.
// Optional glitch counters enabled by defining RPSC_GLITCH_CNT_EN.
module rpsc_interlock_conditioner
    import rpsc_pkg::*;
#(
    parameter int unsigned N_CH       = 8,
    parameter int unsigned DEB_CYCLES = 16,
    parameter int unsigned CNT_W      = $clog2(DEB_CYCLES),
    parameter int unsigned IDX_W      = $clog2(N_CH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_CH-1:0]          i_raw,
    input  logic                     i_ack,
    output logic [N_CH-1:0]          o_clean,
    output logic [N_CH-1:0]          o_rise,
    output logic                     o_any_fault,
    output logic                     o_ff_valid,
    output logic [IDX_W-1:0]         o_ff_idx,
    output logic [GLITCH_W*N_CH-1:0] o_glitch_cnt
);

    logic [N_CH-1:0]   clean;
    logic [N_CH-1:0]   clean_next;
    logic [N_CH-1:0]   rise;
    logic [MAX_CH-1:0] rise_ext;
    logic              any_fault_q;
    logic              ff_valid_q;
    logic              ff_valid_d;
    logic [IDX_W-1:0]  ff_idx_q;
    logic [IDX_W-1:0]  ff_idx_d;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        rpsc_debounce_ch #(
            .DEB_CYCLES (DEB_CYCLES),
            .CNT_W      (CNT_W)
        ) u_ch (
            .clk_i        (clk),
            .rst_i        (reset),
            .raw_i        (i_raw[g]),
`ifdef RPSC_GLITCH_CNT_EN
            .ack_i        (i_ack),
            .glitch_cnt_o (o_glitch_cnt[GLITCH_W*g +: GLITCH_W]),
`endif
            .clean_o      (clean[g]),
            .clean_next_o (clean_next[g]),
            .rise_o       (rise[g])
        );
    end

`ifndef RPSC_GLITCH_CNT_EN
    assign o_glitch_cnt = '0;
`endif

    // Zero-extend rise vector to the width the shared priority helper takes.
    always_comb begin
        rise_ext           = '0;
        rise_ext[N_CH-1:0] = rise;
    end

    // First-fault capture: a rise coinciding with ack re-arms and captures.
    always_comb begin
        ff_valid_d = ff_valid_q;
        ff_idx_d   = ff_idx_q;
        if ((|rise) && (!ff_valid_q || i_ack)) begin
            ff_valid_d = 1'b1;
            ff_idx_d   = IDX_W'(lowest_set_idx(rise_ext));
        end else if (i_ack) begin
            ff_valid_d = 1'b0;
        end
    end

    // Fault summary registered from next-state so it tracks o_clean exactly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            any_fault_q <= 1'b1;
            ff_valid_q  <= 1'b0;
            ff_idx_q    <= '0;
        end else begin
            any_fault_q <= |clean_next;
            ff_valid_q  <= ff_valid_d;
            ff_idx_q    <= ff_idx_d;
        end
    end

    assign o_clean     = clean;
    assign o_rise      = rise;
    assign o_any_fault = any_fault_q;
    assign o_ff_valid  = ff_valid_q;
    assign o_ff_idx    = ff_idx_q;

endmodule

// File: tb/tb_rpsc_interlock_conditioner.sv
// Scoreboard bench for rpsc_interlock_conditioner (N_CH=8, DEB_CYCLES=4).
// Expected glitch counts follow RPSC_GLITCH_CNT_EN.
module tb_rpsc_interlock_conditioner;

`ifdef RPSC_GLITCH_CNT_EN
    localparam logic [63:0] GL = 64'h1;
`else
    localparam logic [63:0] GL = 64'h0;
`endif

    logic        clk;
    logic        reset;
    logic [7:0]  i_raw;
    logic        i_ack;
    logic [7:0]  o_clean;
    logic [7:0]  o_rise;
    logic        o_any_fault;
    logic        o_ff_valid;
    logic [2:0]  o_ff_idx;
    logic [63:0] o_glitch_cnt;

    rpsc_interlock_conditioner #(
        .N_CH       (8),
        .DEB_CYCLES (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_raw        (i_raw),
        .i_ack        (i_ack),
        .o_clean      (o_clean),
        .o_rise       (o_rise),
        .o_any_fault  (o_any_fault),
        .o_ff_valid   (o_ff_valid),
        .o_ff_idx     (o_ff_idx),
        .o_glitch_cnt (o_glitch_cnt)
    );

    typedef struct {
        int unsigned at;
        logic [7:0]  clean;
        logic [7:0]  rise;
        logic        any;
        logic        valid;
        logic [2:0]  idx;
        logic [63:0] glitch;
    } snap_t;

    typedef struct {
        int unsigned at;
        logic [7:0]  val;
    } rise_t;

    snap_t       snap_q[$];
    rise_t       rise_q[$];
    int unsigned edge_cnt = 0;
    int unsigned errors   = 0;
    int unsigned checks   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt = edge_cnt + 1;

    task automatic chk(input string name, input int unsigned at,
                       input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, at, act, exp);
        end
    endtask

    task automatic exp_snap(input int unsigned at, input logic [7:0] clean,
                            input logic [7:0] rise, input logic any,
                            input logic valid, input logic [2:0] idx,
                            input logic [63:0] glitch);
        snap_t s;
        s.at = at; s.clean = clean; s.rise = rise; s.any = any;
        s.valid = valid; s.idx = idx; s.glitch = glitch;
        snap_q.push_back(s);
    endtask

    task automatic exp_rise(input int unsigned at, input logic [7:0] val);
        rise_t r;
        r.at = at; r.val = val;
        rise_q.push_back(r);
    endtask

    // Drive point: 2 time units after posedge number e.
    task automatic goto(input int unsigned e);
        wait (edge_cnt >= e);
        #2;
    endtask

    // Monitor: sample on negedge, pop and compare scheduled expectations.
    always @(negedge clk) begin : monitor
        snap_t s;
        rise_t r;
        if (o_rise != 8'h00) begin
            if (rise_q.size() == 0) begin
                chk("rise_unexpected", edge_cnt, {56'h0, o_rise}, 64'h0);
            end else begin
                r = rise_q.pop_front();
                chk("rise_value", edge_cnt, {56'h0, o_rise}, {56'h0, r.val});
                chk("rise_edge", edge_cnt, 64'(edge_cnt), 64'(r.at));
            end
        end
        while (snap_q.size() > 0 && snap_q[0].at <= edge_cnt) begin
            s = snap_q.pop_front();
            if (s.at != edge_cnt) begin
                chk("snap_missed", s.at, 64'(edge_cnt), 64'(s.at));
            end else begin
                chk("clean",     s.at, {56'h0, o_clean},   {56'h0, s.clean});
                chk("rise",      s.at, {56'h0, o_rise},    {56'h0, s.rise});
                chk("any_fault", s.at, {63'h0, o_any_fault}, {63'h0, s.any});
                chk("ff_valid",  s.at, {63'h0, o_ff_valid},  {63'h0, s.valid});
                chk("ff_idx",    s.at, {61'h0, o_ff_idx},    {61'h0, s.idx});
                chk("glitch",    s.at, o_glitch_cnt, s.glitch);
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int unsigned n;
        int unsigned m;
        int unsigned r;
        reset = 1'b1;
        i_raw = 8'h00;
        i_ack = 1'b0;
        exp_snap(2, 8'hFF, 8'h00, 1'b1, 1'b0, 3'd0, 64'h0);

        // 1: reset release with inputs low
        goto(4);
        reset = 1'b0;
        n = 4;
        exp_snap(n + 5, 8'hFF, 8'h00, 1'b1, 1'b0, 3'd0, 64'h0);
        exp_snap(n + 6, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 64'h0);

        // 2: channel 3 rises and holds
        n = n + 10;
        goto(n);
        i_raw = 8'h08;
        exp_rise(n + 6, 8'h08);
        exp_snap(n + 5, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 64'h0);
        exp_snap(n + 6, 8'h08, 8'h08, 1'b1, 1'b0, 3'd0, 64'h0);
        exp_snap(n + 7, 8'h08, 8'h00, 1'b1, 1'b1, 3'd3, 64'h0);

        // lone ack clears the capture
        m = n + 10;
        goto(m);
        i_ack = 1'b1;
        goto(m + 1);
        i_ack = 1'b0;
        exp_snap(m + 1, 8'h08, 8'h00, 1'b1, 1'b0, 3'd3, 64'h0);

        // 3: channels 2 and 6 together, lowest index wins
        n = m + 4;
        goto(n);
        i_raw = 8'h4C;
        exp_rise(n + 6, 8'h44);
        exp_snap(n + 6, 8'h4C, 8'h44, 1'b1, 1'b0, 3'd3, 64'h0);
        exp_snap(n + 7, 8'h4C, 8'h00, 1'b1, 1'b1, 3'd2, 64'h0);

        // later rise on channel 1 is ignored by the capture
        n = n + 10;
        goto(n);
        i_raw = 8'h4E;
        exp_rise(n + 6, 8'h02);
        exp_snap(n + 6, 8'h4E, 8'h02, 1'b1, 1'b1, 3'd2, 64'h0);
        exp_snap(n + 7, 8'h4E, 8'h00, 1'b1, 1'b1, 3'd2, 64'h0);

        // 4: 3-cycle pulse on channel 0 is rejected
        n = n + 10;
        goto(n);
        i_raw = 8'h4F;
        goto(n + 3);
        i_raw = 8'h4E;
        exp_snap(n + 5, 8'h4E, 8'h00, 1'b1, 1'b1, 3'd2, 64'h0);
        exp_snap(n + 6, 8'h4E, 8'h00, 1'b1, 1'b1, 3'd2, GL);
        exp_snap(n + 8, 8'h4E, 8'h00, 1'b1, 1'b1, 3'd2, GL);

        // 4-cycle pulse is exactly long enough, then falls with no pulse
        n = n + 10;
        goto(n);
        i_raw = 8'h4F;
        goto(n + 4);
        i_raw = 8'h4E;
        exp_rise(n + 6, 8'h01);
        exp_snap(n + 6,  8'h4F, 8'h01, 1'b1, 1'b1, 3'd2, GL);
        exp_snap(n + 9,  8'h4F, 8'h00, 1'b1, 1'b1, 3'd2, GL);
        exp_snap(n + 10, 8'h4E, 8'h00, 1'b1, 1'b1, 3'd2, GL);

        // 5: ack coincident with rise on channel 5 captures the new fault
        n = n + 12;
        goto(n);
        i_raw = 8'h6E;
        exp_rise(n + 6, 8'h20);
        goto(n + 6);
        i_ack = 1'b1;
        exp_snap(n + 6, 8'h6E, 8'h20, 1'b1, 1'b1, 3'd2, GL);
        goto(n + 7);
        i_ack = 1'b0;
        exp_snap(n + 7, 8'h6E, 8'h00, 1'b1, 1'b1, 3'd5, 64'h0);

        m = n + 10;
        goto(m);
        i_ack = 1'b1;
        goto(m + 1);
        i_ack = 1'b0;
        exp_snap(m + 1, 8'h6E, 8'h00, 1'b1, 1'b0, 3'd5, 64'h0);

        // 6: reset mid-qualification of channel 4 (QUAL_HI, cnt = 2)
        n = m + 4;
        goto(n);
        i_raw = 8'h7E;
        goto(n + 4);
        reset = 1'b1;
        i_raw = 8'h00;
        exp_snap(n + 4, 8'hFF, 8'h00, 1'b1, 1'b0, 3'd0, 64'h0);
        exp_snap(n + 6, 8'hFF, 8'h00, 1'b1, 1'b0, 3'd0, 64'h0);
        r = n + 8;
        goto(r);
        reset = 1'b0;
        exp_snap(r + 5, 8'hFF, 8'h00, 1'b1, 1'b0, 3'd0, 64'h0);
        exp_snap(r + 6, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 64'h0);

        // channel 4 needs a full qualification after the reset
        n = r + 10;
        goto(n);
        i_raw = 8'h10;
        exp_rise(n + 6, 8'h10);
        exp_snap(n + 5, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 64'h0);
        exp_snap(n + 6, 8'h10, 8'h10, 1'b1, 1'b0, 3'd0, 64'h0);
        exp_snap(n + 7, 8'h10, 8'h00, 1'b1, 1'b1, 3'd4, 64'h0);

        // drain, bounded
        for (int i = 0; i < 40; i++) begin
            if (snap_q.size() == 0 && rise_q.size() == 0) break;
            @(posedge clk);
        end
        repeat (3) @(posedge clk);
        while (snap_q.size() > 0) begin
            void'(snap_q.pop_front());
            checks++;
            errors++;
            $display("FAIL snap_pending: got none expected snapshot");
        end
        while (rise_q.size() > 0) begin
            void'(rise_q.pop_front());
            checks++;
            errors++;
            $display("FAIL rise_pending: got none expected pulse");
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
